hex_entry: RTL and testbench

Four-digit hexadecimal entry controller that feeds the seven-segment display driver. It drives that driver's `numbers`, `blink` and `enable` inputs.
The user edits a 16-bit value with five push buttons: left, right, up, down and ok. The digit under the cursor blinks, and on confirmation the value is committed to the rest of the design (debug address/register entry).
Raw board buttons are synchronised and debounced inside this block.

---
 rtl/hex_entry.sv | 184 ++++++++++++++++++
 tb/tb_hex_entry.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry.sv
// Four-digit hex entry controller: debounced five-button editor for a 16-bit value,
// driving the seven-segment display's numbers/blink/enable inputs.

// Per-button 2-flop synchroniser, counting debouncer and press-edge detector.
module hex_entry_btn #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            // stage boundary: two-flop synchroniser, then debounce on the synced level
            sync_p0  <= raw;
            sync_p1  <= sync_p0;
            stable_d <= stable;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

module hex_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_ok,
    input  logic        active,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] numbers,
    output logic [3:0]  blink,
    output logic        display_en,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        editing
);

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;
    localparam int B_OK    = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EDIT,
        S_COMMIT
    } state_t;

    logic [4:0] raw;
    logic [4:0] press;

    assign raw = {btn_ok, btn_down, btn_up, btn_right, btn_left};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        hex_entry_btn #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    state_t      state;
    state_t      state_nxt;
    logic [15:0] working;
    logic [15:0] working_nxt;
    logic [15:0] value_nxt;
    logic [1:0]  cursor;
    logic [1:0]  cursor_nxt;
    logic        display_en_nxt;
    logic [3:0]  digit;

    assign digit = working[{cursor, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            value      <= '0;
            working    <= '0;
            cursor     <= '0;
            display_en <= 1'b0;
        end else begin
            state      <= state_nxt;
            value      <= value_nxt;
            working    <= working_nxt;
            cursor     <= cursor_nxt;
            display_en <= display_en_nxt;
        end
    end

    // Only the highest-priority event is acted on: ok > up > down > left > right.
    always_comb begin
        state_nxt      = state;
        value_nxt      = value;
        working_nxt    = working;
        cursor_nxt     = cursor;
        display_en_nxt = display_en;
        numbers        = value;
        blink          = 4'b0000;
        editing        = 1'b0;
        value_valid    = 1'b0;

        case (state)
            S_IDLE: begin
                if (press[B_OK] && active) begin
                    state_nxt   = S_EDIT;
                    working_nxt = value;
                    cursor_nxt  = 2'd0;
                end
                if (load) begin
                    value_nxt      = load_value;
                    display_en_nxt = 1'b1;
                end
            end
            S_EDIT: begin
                numbers = working;
                blink   = 4'b0001 << cursor;
                editing = 1'b1;
                if (!active) begin
                    state_nxt = S_IDLE;
                end else if (press[B_OK]) begin
                    state_nxt = S_COMMIT;
                end else if (press[B_UP]) begin
                    working_nxt[{cursor, 2'b00} +: 4] = digit + 4'd1;
                end else if (press[B_DOWN]) begin
                    working_nxt[{cursor, 2'b00} +: 4] = digit - 4'd1;
                end else if (press[B_LEFT]) begin
                    cursor_nxt = cursor + 2'd1;
                end else if (press[B_RIGHT]) begin
                    cursor_nxt = cursor - 2'd1;
                end
            end
            S_COMMIT: begin
                numbers        = working;
                value_valid    = 1'b1;
                value_nxt      = working;
                display_en_nxt = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: directed scenarios plus randomized button
// sequences compared against an abstract digit-editor model.
module tb_hex_entry;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_up, btn_down, btn_ok;
    logic        active, load;
    logic [15:0] load_value;
    logic [15:0] numbers;
    logic [3:0]  blink;
    logic        display_en;
    logic [15:0] value;
    logic        value_valid;
    logic        editing;

    hex_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_ok     (btn_ok),
        .active     (active),
        .load       (load),
        .load_value (load_value),
        .numbers    (numbers),
        .blink      (blink),
        .display_en (display_en),
        .value      (value),
        .value_valid(value_valid),
        .editing    (editing)
    );

    always #5 clk = ~clk;

    // Button mask bits used by the bench: 0 left, 1 right, 2 up, 3 down, 4 ok.
    localparam int M_LEFT = 1, M_RIGHT = 2, M_UP = 4, M_DOWN = 8, M_OK = 16;

    int n_total = 0;
    int n_pass  = 0;
    int vv_count = 0;

    // Reference model: plain digit-editor state.
    bit m_edit;
    int m_value;
    int m_work;
    int m_cur;
    bit m_disp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (value_valid === 1'b1) vv_count++;
    endtask

    task automatic drive_btns(input int mask);
        btn_left  = mask[0];
        btn_right = mask[1];
        btn_up    = mask[2];
        btn_down  = mask[3];
        btn_ok    = mask[4];
    endtask

    task automatic check_state(input string tag);
        check({tag, ":numbers"}, 32'(numbers), m_edit ? m_work : m_value);
        check({tag, ":blink"},   32'(blink),   m_edit ? (1 << m_cur) : 0);
        check({tag, ":editing"}, 32'(editing), 32'(m_edit));
        check({tag, ":disp"},    32'(display_en), 32'(m_disp));
        check({tag, ":value"},   32'(value),   m_value);
        check({tag, ":vv"},      32'(value_valid), 0);
    endtask

    task automatic model_nib_add(input int d);
        int sh, dig, nd;
        sh  = 4 * m_cur;
        dig = (m_work >> sh) % 16;
        nd  = (dig + d) % 16;
        m_work = m_work - (dig << sh) + (nd << sh);
    endtask

    task automatic model_press(input int mask, output int commits);
        commits = 0;
        if (mask & M_OK) begin
            if (!m_edit) begin
                if (active) begin
                    m_edit = 1;
                    m_work = m_value;
                    m_cur  = 0;
                end
            end else begin
                m_value = m_work;
                m_disp  = 1;
                m_edit  = 0;
                commits = 1;
            end
        end else if (m_edit) begin
            if (mask & M_UP)         model_nib_add(1);
            else if (mask & M_DOWN)  model_nib_add(15);
            else if (mask & M_LEFT)  m_cur = (m_cur + 1) % 4;
            else if (mask & M_RIGHT) m_cur = (m_cur + 3) % 4;
        end
    endtask

    task automatic press(input int mask, input string tag);
        int exp_commits;
        vv_count = 0;
        drive_btns(mask);
        repeat (8) tick();
        drive_btns(0);
        repeat (8) tick();
        model_press(mask, exp_commits);
        check({tag, ":vv_pulses"}, 32'(vv_count), 32'(exp_commits));
        check_state(tag);
    endtask

    task automatic set_active(input bit a, input string tag);
        vv_count = 0;
        active = a;
        tick();
        tick();
        if (!a) m_edit = 0;
        check({tag, ":vv_pulses"}, 32'(vv_count), 0);
        check_state(tag);
    endtask

    task automatic do_load(input logic [15:0] v, input string tag);
        load = 1'b1;
        load_value = v;
        tick();
        load = 1'b0;
        tick();
        if (!m_edit) begin
            m_value = v;
            m_disp  = 1;
        end
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        drive_btns(0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_edit = 0; m_value = 0; m_work = 0; m_cur = 0; m_disp = 0;
        check_state(tag);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        drive_btns(0);
        active = 1'b0;
        load = 1'b0;
        load_value = '0;
        m_edit = 0; m_value = 0; m_work = 0; m_cur = 0; m_disp = 0;
        tick();
        tick();
        check("rst:numbers", 32'(numbers), 0);
        check("rst:blink", 32'(blink), 0);
        check("rst:disp", 32'(display_en), 0);
        check("rst:value", 32'(value), 0);
        check("rst:editing", 32'(editing), 0);
        check("rst:vv", 32'(value_valid), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Edit flow
        set_active(1, "act_on");
        do_load(16'h12AF, "load1");
        check("load1:value_const", 32'(value), 32'h12AF);
        press(M_OK, "enter");
        check("enter:blink_const", 32'(blink), 32'h1);

        // Glitch of 3 cycles must not register
        btn_up = 1'b1;
        repeat (3) tick();
        btn_up = 1'b0;
        repeat (10) tick();
        check("glitch:numbers", 32'(numbers), 32'h12AF);

        // Held press: event lands exactly D+3 edges after the raw edge, only once
        btn_up = 1'b1;
        repeat (D + 2) tick();
        check("deb_early:numbers", 32'(numbers), 32'h12AF);
        tick();
        check("deb_edge:numbers", 32'(numbers), 32'h12A0);
        repeat (10 - (D + 3)) tick();
        btn_up = 1'b0;
        repeat (10) tick();
        model_nib_add(1);
        check_state("deb_once");

        press(M_LEFT, "left1");
        press(M_DOWN, "down1");
        check("down1:numbers_const", 32'(numbers), 32'h1290);
        check("down1:blink_const", 32'(blink), 32'h2);
        press(M_OK, "commit1");
        check("commit1:value_const", 32'(value), 32'h1290);

        // Cursor wrap
        press(M_OK, "enter2");
        press(M_RIGHT, "right_wrap");
        check("right_wrap:blink_const", 32'(blink), 32'h8);
        for (int i = 0; i < 4; i++) press(M_LEFT, "left_loop");
        check("left_loop:blink_const", 32'(blink), 32'h8);

        // Abort discards working
        press(M_UP, "mod_before_abort");
        set_active(0, "abort");
        check("abort:numbers_const", 32'(numbers), 32'h1290);
        set_active(1, "act_on2");

        // ok and up together: commit only
        press(M_OK, "enter3");
        press(M_OK | M_UP, "ok_up");
        check("ok_up:value_const", 32'(value), 32'h1290);

        // Load ignored while editing, accepted when idle
        press(M_OK, "enter4");
        do_load(16'hBEEF, "load_edit");
        check("load_edit:value_const", 32'(value), 32'h1290);
        press(M_OK, "commit4");
        do_load(16'hBEEF, "load_idle");
        check("load_idle:value_const", 32'(value), 32'hBEEF);

        // Reset mid-edit
        press(M_OK, "enter5");
        press(M_DOWN, "down5");
        do_reset("rst_mid");

        // Randomized sequences
        set_active(1, "act_on3");
        for (int n = 0; n < 50; n++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op <= 5) press(1 << $urandom_range(0, 4), "rnd_single");
            else if (op <= 7) press($urandom_range(1, 31), "rnd_multi");
            else if (op == 8) do_load(16'($urandom), "rnd_load");
            else if (op == 9) set_active($urandom_range(0, 2) != 0, "rnd_active");
            else if (op == 10) set_active(1, "rnd_active1");
            else if ($urandom_range(0, 3) == 0) do_reset("rnd_reset");
            else press(M_OK, "rnd_ok");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
